// File: rtl/ifetch_stage.sv
// Instruction fetch stage: PC register, one-outstanding imem request, InstCode output slot.
// Optional redirect-target alignment checking under `IFETCH_MISALIGN_CHECK_EN.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] InstCode,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_code_q, inst_code_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] redirect_tgt;
  logic        redirect_misaligned;
  logic        slot_free;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign redirect_tgt        = redirect_pc;
  assign redirect_misaligned = |redirect_pc[1:0];
`else
  assign redirect_tgt        = redirect_pc & 32'hFFFF_FFFC;
  assign redirect_misaligned = 1'b0;
`endif

  assign slot_free   = !inst_valid_q || inst_ready;
  // rst_n gates the request so nothing leaves the stage while reset is held.
  assign imem_req    = rst_n && (state_q == S_IDLE) && slot_free && !redirect_valid && !fault_q;
  assign imem_addr   = pc_q;
  assign InstCode    = inst_code_q;
  assign inst_pc     = inst_pc_q;
  assign inst_valid  = inst_valid_q;
  assign fetch_fault = fault_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_code_d  = inst_code_q;
    inst_pc_d    = inst_pc_q;
    fault_d      = fault_q;
    inst_valid_d = inst_valid_q && !inst_ready;
    if (redirect_valid) begin
      // A response landing alongside a redirect belongs to the old path.
      pc_d         = redirect_tgt;
      inst_valid_d = 1'b0;
      fault_d      = redirect_misaligned;
      if (state_q != S_IDLE) state_d = imem_rvalid ? S_IDLE : S_DROP;
    end else begin
      unique case (state_q)
        S_IDLE: if (imem_req) state_d = S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            inst_code_d  = imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
            state_d      = S_IDLE;
          end
        end
        S_DROP: if (imem_rvalid) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_code_q  <= 32'h0;
      inst_pc_q    <= 32'h0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_code_q  <= inst_code_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// Scoreboard bench for ifetch_stage: directed stimulus, memory model returns addr+0x513.
// Build with +define+IFETCH_MISALIGN_CHECK_EN to exercise the alignment-check variant.
module tb_ifetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] InstCode;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        fetch_fault;

  int          n_checks = 0;
  int          n_fail = 0;
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] exp_code_q[$];
  logic [31:0] exp_pc_q[$];

  ifetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .InstCode(InstCode), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] code, input logic [31:0] pc);
    exp_code_q.push_back(code);
    exp_pc_q.push_back(pc);
  endtask

  // Inputs change at negedge+1, DUT outputs are checked at negedge+2.
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_valid(input string name, input int max);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      nxt();
      settle();
      if (inst_valid) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: inst_valid not seen within %0d cycles, required 1", name, max);
    end
  endtask

  // Memory model: one request at a time, response mem_lat cycles later.
  always @(negedge clk) begin
    #3;
    imem_rvalid = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_addr + 32'h0000_0513;
      end
    end
    if (imem_req) begin
      mem_cnt  = mem_lat;
      mem_addr = imem_addr;
    end
  end

  // Monitor: every transfer to decode is compared against the scoreboard head.
  always @(negedge clk) begin
    #4;
    if (rst_n && inst_valid && inst_ready) begin
      if (exp_code_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got InstCode=%h inst_pc=%h, required no transfer", InstCode, inst_pc);
      end else begin
        check("sb_code", InstCode, exp_code_q.pop_front());
        check("sb_pc", inst_pc, exp_pc_q.pop_front());
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(posedge clk);
    nxt(); settle();
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_code", InstCode, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_fault", {31'b0, fetch_fault}, 32'h0);

    // Reset release and first fetch
    push(32'h0000_0513, 32'h0);
    push(32'h0000_0517, 32'h4);
    nxt(); rst_n = 1'b1; settle();
    check("first_req", {31'b0, imem_req}, 32'h1);
    check("first_addr", imem_addr, 32'h0);
    nxt(); settle();
    check("wait_noreq", {31'b0, imem_req}, 32'h0);
    nxt(); settle();
    check("first_valid", {31'b0, inst_valid}, 32'h1);
    check("first_code", InstCode, 32'h0000_0513);
    check("first_ipc", inst_pc, 32'h0);
    check("second_req", {31'b0, imem_req}, 32'h1);
    check("second_addr", imem_addr, 32'h4);
    nxt(); settle();
    check("consumed_valid", {31'b0, inst_valid}, 32'h0);

    // Decode stall for 5 cycles
    nxt(); inst_ready = 1'b0; settle();
    check("stall_valid", {31'b0, inst_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin nxt(); settle(); end
      check("stall_noreq", {31'b0, imem_req}, 32'h0);
      check("stall_code", InstCode, 32'h0000_0517);
      check("stall_ipc", inst_pc, 32'h4);
    end
    push(32'h0000_051B, 32'h8);
    nxt(); inst_ready = 1'b1; settle();
    check("unstall_req", {31'b0, imem_req}, 32'h1);
    check("unstall_addr", imem_addr, 32'h8);
    nxt(); settle();
    nxt(); inst_ready = 1'b0; settle();
    check("pc8_valid", {31'b0, inst_valid}, 32'h1);
    check("pc8_ipc", inst_pc, 32'h8);

    // Redirect during WAIT, memory latency 3
    mem_lat = 3;
    nxt(); inst_ready = 1'b1; settle();
    check("rw_req", imem_addr, 32'hC);
    nxt(); inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; settle();
    check("rw_redir_noreq", {31'b0, imem_req}, 32'h0);
    nxt(); redirect_valid = 1'b0; settle();
    check("rw_addr", imem_addr, 32'h100);
    check("rw_drop_noreq", {31'b0, imem_req}, 32'h0);
    nxt(); settle();
    check("rw_drop_noreq2", {31'b0, imem_req}, 32'h0);
    push(32'h0000_0613, 32'h100);
    nxt(); settle();
    check("rw_req_tgt", {31'b0, imem_req}, 32'h1);
    check("rw_addr_tgt", imem_addr, 32'h100);
    check("rw_valid0", {31'b0, inst_valid}, 32'h0);
    wait_valid("rw_fetch", 10);
    check("rw_ipc", inst_pc, 32'h100);

    // Redirect coincident with the response
    nxt(); inst_ready = 1'b1; settle();
    check("rc_addr", imem_addr, 32'h104);
    nxt(); inst_ready = 1'b0; settle();
    nxt(); settle();
    nxt(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; settle();
    push(32'h0000_0813, 32'h300);
    nxt(); redirect_valid = 1'b0; settle();
    check("rc_req", {31'b0, imem_req}, 32'h1);
    check("rc_addr_tgt", imem_addr, 32'h300);
    check("rc_valid0", {31'b0, inst_valid}, 32'h0);
    wait_valid("rc_fetch", 10);

    // PC wrap
    mem_lat = 1;
    nxt(); inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; settle();
    check("wrap_redir_noreq", {31'b0, imem_req}, 32'h0);
    push(32'h0000_050F, 32'hFFFF_FFFC);
    nxt(); inst_ready = 1'b0; redirect_valid = 1'b0; settle();
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    wait_valid("wrap_fetch", 6);
    check("wrap_ipc", inst_pc, 32'hFFFF_FFFC);
    check("wrap_next_addr", imem_addr, 32'h0);

    // Misaligned redirect
    nxt(); inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0102; settle();
    nxt(); inst_ready = 1'b0; redirect_valid = 1'b0; settle();
`ifdef IFETCH_MISALIGN_CHECK_EN
    check("mis_fault", {31'b0, fetch_fault}, 32'h1);
    check("mis_addr", imem_addr, 32'h102);
    for (int i = 0; i < 3; i++) begin
      check("mis_noreq", {31'b0, imem_req}, 32'h0);
      nxt(); settle();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    nxt(); redirect_valid = 1'b0; settle();
    check("mis_clear", {31'b0, fetch_fault}, 32'h0);
    check("mis_req", {31'b0, imem_req}, 32'h1);
    check("mis_addr_ok", imem_addr, 32'h200);
    push(32'h0000_0713, 32'h200);
`else
    check("mis_fault0", {31'b0, fetch_fault}, 32'h0);
    check("mis_req", {31'b0, imem_req}, 32'h1);
    check("mis_addr_forced", imem_addr, 32'h100);
    push(32'h0000_0613, 32'h100);
`endif
    wait_valid("mis_fetch", 6);

    // Reset mid-request; late response arrives while reset is held
    mem_lat = 5;
    nxt(); inst_ready = 1'b1; settle();
    check("mr_req", {31'b0, imem_req}, 32'h1);
    nxt(); inst_ready = 1'b0; rst_n = 1'b0; settle();
    check("mr_rst_noreq", {31'b0, imem_req}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      nxt(); settle();
      check("mr_rst_noreq", {31'b0, imem_req}, 32'h0);
    end
    push(32'h0000_0513, 32'h0);
    nxt(); rst_n = 1'b1; settle();
    check("mr_req_after", {31'b0, imem_req}, 32'h1);
    check("mr_addr_after", imem_addr, 32'h0);
    check("mr_valid0", {31'b0, inst_valid}, 32'h0);
    wait_valid("mr_fetch", 12);
    check("mr_ipc", inst_pc, 32'h0);
    nxt(); inst_ready = 1'b1; settle();
    nxt(); inst_ready = 1'b0; settle();
    nxt(); settle();
    check("sb_drained", exp_code_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
